memory_stage: RTL and testbench

- Sequential Y86-64 memory stage, directly downstream of the execute stage.
- Consumes icode, valE, valA and valP for one instruction. Performs at most one 64-bit data-memory read or write over a req/ack handshake, then returns valM and an updated status code to write-back.
- Includes an address-bound check and an ack timeout that both report ADR.

---
 rtl/memory_stage_if.sv | 25 ++
 rtl/memory_stage.sv | 171 +++++++++++++++++
 tb/tb_memory_stage.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/memory_stage_if.sv
// memory_stage_if: data-memory bus between the Y86-64 memory stage and memory.
//   mem_req   - request, held until ack or abort (master -> slave)
//   mem_we    - 1=write, 0=read, valid while mem_req (master -> slave)
//   mem_addr  - byte address, valid while mem_req (master -> slave)
//   mem_wdata - write data, valid while mem_req (master -> slave)
//   mem_rdata - read data, valid with mem_ack (slave -> master)
//   mem_ack   - request completes this cycle (slave -> master)
interface memory_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/memory_stage.sv
// memory_stage: sequential Y86-64 memory stage.
// Takes icode/valE/valA/valP/stat_in for one instruction, performs at most one
// 64-bit read or write over the req/ack bus, then returns valM and stat_out.
// Out-of-range addresses and an ack timeout both report ADR (3).
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start               - accept an instruction (only looked at in IDLE)
//   icode, valE, valA,
//   valP, stat_in       - instruction fields from execute
//   busy                - high in ACCESS and RESP
//   done                - one-cycle pulse, valM/stat_out valid
//   valM, stat_out      - results, held until the next done
//   mem                 - memory bus (memory_stage_if.master)
//
// Optional build macro: MEM_ALIGN_CHECK_EN - when defined, an access address
// with addr[2:0] != 0 is treated as an address error and never reaches memory.
module memory_stage #(
  parameter int MEM_BYTES = 8192,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [3:0]           icode,
  input  logic [63:0]          valE,
  input  logic [63:0]          valA,
  input  logic [63:0]          valP,
  input  logic [2:0]           stat_in,
  output logic                 busy,
  output logic                 done,
  output logic [63:0]          valM,
  output logic [2:0]           stat_out,
  memory_stage_if.master       mem
);

  localparam logic [3:0] I_RMMOVQ = 4'd4;
  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_CALL   = 4'd8;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_PUSHQ  = 4'd10;
  localparam logic [3:0] I_POPQ   = 4'd11;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_ADR = 3'd3;

  localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);

  // Counter must be able to hold the value TIMEOUT itself.
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t          state_reg;
  logic [3:0]      icode_reg;
  logic [2:0]      stat_reg;
  logic [CW-1:0]   cnt_reg;

  // Decode straight from the inputs so the IDLE decision is made in the
  // same cycle start is accepted.
  logic        is_read_in;
  logic        is_write_in;
  logic        access_in;
  logic [63:0] addr_in;
  logic [63:0] wdata_in;
  logic        addr_err_in;
  logic        latched_is_read;

  always_comb begin
    is_read_in  = (icode == I_MRMOVQ) || (icode == I_RET) || (icode == I_POPQ);
    is_write_in = (icode == I_RMMOVQ) || (icode == I_CALL) || (icode == I_PUSHQ);
    access_in   = is_read_in || is_write_in;
    // ret/popq read from the old stack pointer (valA), everything else uses valE.
    addr_in     = ((icode == I_RET) || (icode == I_POPQ)) ? valA : valE;
    wdata_in    = (icode == I_CALL) ? valP : valA;
`ifdef MEM_ALIGN_CHECK_EN
    addr_err_in = access_in && ((addr_in > MAX_ADDR) || (addr_in[2:0] != 3'd0));
`else
    addr_err_in = access_in && (addr_in > MAX_ADDR);
`endif
    latched_is_read = (icode_reg == I_MRMOVQ) || (icode_reg == I_RET) ||
                      (icode_reg == I_POPQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      icode_reg     <= 4'd0;
      stat_reg      <= S_AOK;
      cnt_reg       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      valM          <= 64'd0;
      stat_out      <= S_AOK;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= 64'd0;
      mem.mem_wdata <= 64'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            icode_reg <= icode;
            stat_reg  <= stat_in;
            busy      <= 1'b1;
            if ((stat_in != S_AOK) || !access_in || addr_err_in) begin
              // Nothing to do on the bus: report straight away.
              state_reg <= RESP;
              done      <= 1'b1;
              valM      <= 64'd0;
              if (stat_in != S_AOK)
                stat_out <= stat_in;
              else if (addr_err_in)
                stat_out <= S_ADR;
              else
                stat_out <= stat_in;
            end else begin
              state_reg     <= ACCESS;
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= is_write_in;
              mem.mem_addr  <= addr_in;
              mem.mem_wdata <= wdata_in;
              cnt_reg       <= '0;
            end
          end
        end

        ACCESS: begin
          // Ack is checked first so an ack on the final allowed cycle wins.
          if (mem.mem_ack) begin
            valM        <= latched_is_read ? mem.mem_rdata : 64'd0;
            stat_out    <= stat_reg;
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            state_reg   <= RESP;
            done        <= 1'b1;
          end else if (cnt_reg + CW'(1) == CW'(TIMEOUT)) begin
            valM        <= 64'd0;
            stat_out    <= S_ADR;
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            state_reg   <= RESP;
            done        <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end

        RESP: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg   <= IDLE;
          done        <= 1'b0;
          busy        <= 1'b0;
          mem.mem_req <= 1'b0;
          mem.mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: self-checking bench for memory_stage.
// A vector table drives one instruction per entry; a bench-side responder
// acks the bus after a per-vector delay (or never). Expected results are
// queued when the instruction is driven and popped when done pulses.
// Hand-written sequences cover reset mid-access and ack outside ACCESS.
// Honours MEM_ALIGN_CHECK_EN for the unaligned-write vector.
module tb_memory_stage;

  localparam int MEM_BYTES = 8192;
  localparam int TIMEOUT   = 16;
  localparam int NV        = 14;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] valE, valA, valP;
  logic [2:0]  stat_in;
  logic        busy, done;
  logic [63:0] valM;
  logic [2:0]  stat_out;

  memory_stage_if mem_bus ();

  memory_stage #(.MEM_BYTES(MEM_BYTES), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .icode    (icode),
    .valE     (valE),
    .valA     (valA),
    .valP     (valP),
    .stat_in  (stat_in),
    .busy     (busy),
    .done     (done),
    .valM     (valM),
    .stat_out (stat_out),
    .mem      (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  icode;
    logic [63:0] valE, valA, valP;
    logic [2:0]  stat_in;
    int          ack_delay;   // wait cycles before ack, -1 = never
    logic [63:0] rdata;
    bit          exp_acc;
    bit          exp_we;
    logic [63:0] exp_addr, exp_wdata, exp_valM;
    logic [2:0]  exp_stat;
    int          exp_lat;
  } vec_t;

  vec_t vecs[NV];
  vec_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   c;
    int   req_cycles;
    int   exp_req;
    bit   seen_done;
    vec_t e;
    start   = 1'b1;
    icode   = v.icode;
    valE    = v.valE;
    valA    = v.valA;
    valP    = v.valP;
    stat_in = v.stat_in;
    exp_q.push_back(v);
    @(posedge clk); #1;
    c = 1;
    req_cycles = 0;
    seen_done = 1'b0;
    chk({v.name, " busy_c1"}, 64'(busy), 64'd1);
    while (c < 40 && !seen_done) begin
      // A start during ACCESS/RESP must be ignored.
      start = (c == 1);
      icode = 4'd0; valE = 64'd0; valA = 64'd0; valP = 64'd0;
      mem_bus.mem_ack   = 1'b0;
      mem_bus.mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      if (mem_bus.mem_req) begin
        req_cycles++;
        chk({v.name, " addr"}, mem_bus.mem_addr, v.exp_addr);
        chk({v.name, " we"}, 64'(mem_bus.mem_we), 64'(v.exp_we));
        if (v.exp_we) chk({v.name, " wdata"}, mem_bus.mem_wdata, v.exp_wdata);
        if (req_cycles - 1 == v.ack_delay) begin
          mem_bus.mem_ack   = 1'b1;
          mem_bus.mem_rdata = v.rdata;
        end
      end
      if (done) begin
        seen_done = 1'b1;
        e = exp_q.pop_front();
        exp_req = !e.exp_acc ? 0 : (e.ack_delay < 0 ? TIMEOUT : e.ack_delay + 1);
        chk({e.name, " valM"}, valM, e.exp_valM);
        chk({e.name, " stat"}, 64'(stat_out), 64'(e.exp_stat));
        chk({e.name, " latency"}, 64'(c), 64'(e.exp_lat));
        chk({e.name, " req_cycles"}, 64'(req_cycles), 64'(exp_req));
      end else begin
        @(posedge clk); #1;
        c++;
      end
    end
    start = 1'b0;
    mem_bus.mem_ack = 1'b0;
    if (!seen_done) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s done_timeout: got no done expected done within 40 cycles", v.name);
      void'(exp_q.pop_front());
    end
    @(posedge clk); #1;
    chk({v.name, " busy_after"}, 64'(busy), 64'd0);
    chk({v.name, " done_after"}, 64'(done), 64'd0);
    $display("txn %-10s icode=%0d stat=%0d valM=0x%0h cycles=%0d", v.name, v.icode, stat_out, valM, c);
  endtask

  initial begin
    //        name        icode valE                    valA          valP     st dly rdata                  acc we addr                    wdata    valM                   stat lat
    vecs[0]  = '{"mrmovq",  4'd5,  64'h100,               64'h0,        64'h0,   3'd1, 0, 64'hDEADBEEF, 1'b1, 1'b0, 64'h100, 64'h0, 64'hDEADBEEF, 3'd1, 2};
    vecs[1]  = '{"nop_clr", 4'd1,  64'h0,                 64'h0,        64'h0,   3'd1, 0, 64'h0,        1'b0, 1'b0, 64'h0,   64'h0, 64'h0,        3'd1, 1};
    vecs[2]  = '{"pushq",   4'd10, 64'h1F8,               64'h55,       64'h0,   3'd1, 0, 64'h0,        1'b1, 1'b1, 64'h1F8, 64'h55, 64'h0,       3'd1, 2};
    vecs[3]  = '{"call",    4'd8,  64'h1F0,               64'h77,       64'h40,  3'd1, 0, 64'h0,        1'b1, 1'b1, 64'h1F0, 64'h40, 64'h0,       3'd1, 2};
    vecs[4]  = '{"popq",    4'd11, 64'h208,               64'h200,      64'h0,   3'd1, 2, 64'h1234,     1'b1, 1'b0, 64'h200, 64'h0, 64'h1234,     3'd1, 4};
    vecs[5]  = '{"ret_edge",4'd9,  64'h0,                 64'h1FF8,     64'h0,   3'd1, 1, 64'hCAFE,     1'b1, 1'b0, 64'h1FF8, 64'h0, 64'hCAFE,    3'd1, 3};
    vecs[6]  = '{"opq",     4'd6,  64'h100,               64'h1,        64'h0,   3'd1, 0, 64'h0,        1'b0, 1'b0, 64'h0,   64'h0, 64'h0,        3'd1, 1};
    vecs[7]  = '{"oob",     4'd5,  64'(MEM_BYTES - 7),    64'h0,        64'h0,   3'd1, 0, 64'h0,        1'b0, 1'b0, 64'h0,   64'h0, 64'h0,        3'd3, 1};
    vecs[8]  = '{"huge",    4'd5,  64'hFFFF_FFFF_FFFF_FFF8, 64'h0,      64'h0,   3'd1, 0, 64'h0,        1'b0, 1'b0, 64'h0,   64'h0, 64'h0,        3'd3, 1};
    vecs[9]  = '{"hlt_in",  4'd4,  64'h100,               64'h9,        64'h0,   3'd2, 0, 64'h0,        1'b0, 1'b0, 64'h0,   64'h0, 64'h0,        3'd2, 1};
    vecs[10] = '{"tmo",     4'd5,  64'h100,               64'h0,        64'h0,   3'd1, -1, 64'h0,       1'b1, 1'b0, 64'h100, 64'h0, 64'h0,        3'd3, TIMEOUT + 1};
    vecs[11] = '{"ack_last",4'd5,  64'h108,               64'h0,        64'h0,   3'd1, TIMEOUT - 1, 64'hABC, 1'b1, 1'b0, 64'h108, 64'h0, 64'hABC, 3'd1, TIMEOUT + 1};
`ifdef MEM_ALIGN_CHECK_EN
    vecs[12] = '{"unalign", 4'd4,  64'h104,               64'h99,       64'h0,   3'd1, 0, 64'h0,        1'b0, 1'b0, 64'h0,   64'h0, 64'h0,        3'd3, 1};
`else
    vecs[12] = '{"unalign", 4'd4,  64'h104,               64'h99,       64'h0,   3'd1, 0, 64'h0,        1'b1, 1'b1, 64'h104, 64'h99, 64'h0,       3'd1, 2};
`endif
    vecs[13] = '{"ins_in",  4'd0,  64'h0,                 64'h0,        64'h0,   3'd4, 0, 64'h0,        1'b0, 1'b0, 64'h0,   64'h0, 64'h0,        3'd4, 1};

    rst_n = 1'b0;
    start = 1'b0;
    icode = 4'd0; valE = 64'd0; valA = 64'd0; valP = 64'd0; stat_in = 3'd1;
    mem_bus.mem_ack = 1'b0;
    mem_bus.mem_rdata = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst req", 64'(mem_bus.mem_req), 64'd0);
    chk("rst we", 64'(mem_bus.mem_we), 64'd0);
    chk("rst valM", valM, 64'd0);
    chk("rst addr", mem_bus.mem_addr, 64'd0);
    chk("rst stat", 64'(stat_out), 64'd1);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // Ack outside ACCESS must not start anything.
    mem_bus.mem_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mem_bus.mem_ack = 1'b0;
    chk("idle_ack busy", 64'(busy), 64'd0);
    chk("idle_ack done", 64'(done), 64'd0);
    chk("idle_ack req", 64'(mem_bus.mem_req), 64'd0);
    $display("txn idle_ack  busy=%0d done=%0d", busy, done);

    // Reset in the middle of an access: request drops at once, no done later.
    start = 1'b1; icode = 4'd5; valE = 64'h180; valA = 64'd0; valP = 64'd0; stat_in = 3'd1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("midrst req_before", 64'(mem_bus.mem_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst req", 64'(mem_bus.mem_req), 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst stat", 64'(stat_out), 64'd1);
    chk("midrst done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("midrst no_done", 64'(done), 64'd0);
      chk("midrst idle", 64'(busy), 64'd0);
    end
    $display("txn mid_reset req=%0d busy=%0d stat=%0d", mem_bus.mem_req, busy, stat_out);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
